// File: rtl/axi_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_port_arbiter
// Brief    : Round-robin two-requester arbiter/sequencer for one AXI port
// Revision : 1.0
// ============================================================================
module axi_port_arbiter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m0_rd_en,
  input  logic                      m0_wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]               m0_wr_data,
  input  logic [3:0]                m0_wr_strobe,
  output logic [31:0]               m0_rd_data,
  output logic                      m0_busy,
  output logic                      m0_access_fault,
  input  logic                      m1_rd_en,
  input  logic                      m1_wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]               m1_wr_data,
  input  logic [3:0]                m1_wr_strobe,
  output logic [31:0]               m1_rd_data,
  output logic                      m1_busy,
  output logic                      m1_access_fault,
  output logic                      axi_rd_en,
  output logic                      axi_wr_en,
  output logic [AXI_ADDR_WIDTH-1:0] axi_addr,
  output logic [31:0]               axi_wr_data,
  output logic [3:0]                axi_wr_strobe,
  input  logic [31:0]               axi_rd_data,
  input  logic                      axi_busy,
  input  logic                      axi_access_fault,
  output logic [1:0]                grant
);

  // A zero-width counter is illegal, so the disabled-timeout case keeps one bit.
  localparam int                 c_cnt_w    = (TIMEOUT_WIDTH < 1) ? 1 : TIMEOUT_WIDTH;
  localparam bit                 c_to_en    = (TIMEOUT_CYCLES > 0);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_to_en ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_last_grant;
  logic [c_cnt_w-1:0]   r_cnt;

  logic                 w_req0, w_req1;
  logic                 w_granted, w_sel1;
  logic                 w_req_g, w_rd_g, w_wr_g;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_g;
  logic [31:0]          w_wdata_g;
  logic [3:0]           w_strb_g;
  logic                 w_timeout_hit;
  logic                 w_set_last;
  logic                 w_busy_g;
  logic [31:0]          w_rdata_g;
  logic                 w_fault_g;
  logic                 w_axi_rd, w_axi_wr;

  assign w_req0    = m0_rd_en | m0_wr_en;
  assign w_req1    = m1_rd_en | m1_wr_en;
  assign w_sel1    = (r_state == ST_GNT1);
  assign w_granted = (r_state == ST_GNT0) || (r_state == ST_GNT1);

  // Write wins when a requester raises both enables.
  assign w_req_g   = w_sel1 ? w_req1 : w_req0;
  assign w_wr_g    = w_sel1 ? m1_wr_en : m0_wr_en;
  assign w_rd_g    = (w_sel1 ? m1_rd_en : m0_rd_en) & ~w_wr_g;
  assign w_addr_g  = w_sel1 ? m1_addr : m0_addr;
  assign w_wdata_g = w_sel1 ? m1_wr_data : m0_wr_data;
  assign w_strb_g  = w_sel1 ? m1_wr_strobe : m0_wr_strobe;

  assign w_timeout_hit = c_to_en && w_granted && axi_busy && (r_cnt == c_cnt_last);

  always_comb begin
    w_state_next = r_state;
    w_set_last   = 1'b0;
    w_busy_g     = 1'b0;
    w_rdata_g    = '0;
    w_fault_g    = 1'b0;
    w_axi_rd     = 1'b0;
    w_axi_wr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) w_state_next = r_last_grant ? ST_GNT0 : ST_GNT1;
        else if (w_req0)      w_state_next = ST_GNT0;
        else if (w_req1)      w_state_next = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        if (!w_req_g) begin
          w_state_next = ST_IDLE;
        end else if (w_timeout_hit) begin
          w_fault_g    = 1'b1;
          w_set_last   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (!axi_busy) begin
          w_axi_rd     = w_rd_g;
          w_axi_wr     = w_wr_g;
          w_rdata_g    = axi_rd_data;
          w_fault_g    = axi_access_fault;
          w_set_last   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_axi_rd     = w_rd_g;
          w_axi_wr     = w_wr_g;
          w_busy_g     = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_set_last) r_last_grant <= w_sel1;
      if (w_state_next == ST_IDLE)   r_cnt <= '0;
      else if (w_granted && axi_busy) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign axi_rd_en     = w_axi_rd;
  assign axi_wr_en     = w_axi_wr;
  assign axi_addr      = w_granted ? w_addr_g : '0;
  assign axi_wr_data   = w_granted ? w_wdata_g : '0;
  assign axi_wr_strobe = w_granted ? w_strb_g : '0;

  // Busy is gated by rst_n so every output reads 0 while reset is held.
  assign m0_busy         = rst_n & ((r_state == ST_GNT0) ? w_busy_g : w_req0);
  assign m1_busy         = rst_n & ((r_state == ST_GNT1) ? w_busy_g : w_req1);
  assign m0_rd_data      = (r_state == ST_GNT0) ? w_rdata_g : '0;
  assign m1_rd_data      = (r_state == ST_GNT1) ? w_rdata_g : '0;
  assign m0_access_fault = (r_state == ST_GNT0) & w_fault_g;
  assign m1_access_fault = (r_state == ST_GNT1) & w_fault_g;
  assign grant           = {(r_state == ST_GNT1), (r_state == ST_GNT0)};

endmodule
`default_nettype wire

// File: doc/axi_port_arbiter.md
Name: axi_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the core's single AXI address-space port (rd_en/wr_en/addr/wr_data/wr_strobe in, rd_data/busy/access_fault back).
- Requester 0 is the core DBus AXI path. Requester 1 is a secondary master (DMA/debug).
- Grants are registered and round-robin on contention. A grant is held until the transfer completes, is withdrawn, or times out.
- Sits between the core AXI port outputs and the AXI bridge.

Parameters:
- AXI_ADDR_WIDTH, 32, byte address width of the AXI address space.
- TIMEOUT_CYCLES, 255, maximum consecutive granted cycles with axi_busy=1 before abort; 0 disables the timeout.
- TIMEOUT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived).

Ports:
- clk  in  1  global system clock
- rst_n  in  1  asynchronous reset, active-low
- m0_rd_en, m1_rd_en  in  1  requester read request (level, held until not busy)
- m0_wr_en, m1_wr_en  in  1  requester write request (level)
- m0_addr, m1_addr  in  AXI_ADDR_WIDTH  requester byte address
- m0_wr_data, m1_wr_data  in  32  requester write data
- m0_wr_strobe, m1_wr_strobe  in  4  requester byte strobes
- m0_rd_data, m1_rd_data  out  32  read data, valid in completion cycle
- m0_busy, m1_busy  out  1  requester must hold request stable
- m0_access_fault, m1_access_fault  out  1  completion with fault
- axi_rd_en, axi_wr_en  out  1  downstream request
- axi_addr  out  AXI_ADDR_WIDTH  downstream address
- axi_wr_data  out  32  downstream write data
- axi_wr_strobe  out  4  downstream strobes
- axi_rd_data  in  32  downstream read data
- axi_busy  in  1  downstream not ready
- axi_access_fault  in  1  downstream fault, valid when axi_busy=0
- grant  out  2  one-hot current grant (debug/observability)

Behaviour:
Request qualification:
- req_i = mi_rd_en | mi_wr_en.
- If both rd_en and wr_en are asserted, the write wins: rd_en is masked on the forwarded request.

State machine (registered): IDLE, GNT0, GNT1.
- Reset: state IDLE, last_grant = 1 (so m0 wins the first contention), timeout counter 0.
- IDLE:
  - No downstream enables; all axi_* outputs 0.
  - mi_busy = req_i.
  - Next state: req_0 only -> GNT0; req_1 only -> GNT1; both -> grant the requester != last_grant.
  - This costs exactly 1 arbitration cycle.
- GNTi:
  - axi_* outputs pass through mi_* combinationally; the other requester sees busy = its req.
  - mi_busy = req_i & axi_busy & !timeout_hit.
  - Completion = req_i & !axi_busy. In that cycle:
    - mi_rd_data = axi_rd_data;
    - mi_access_fault = axi_access_fault;
    - last_grant <= i;
    - next state IDLE.
  - Withdrawal (req_i = 0): axi enables 0, next state IDLE, last_grant unchanged, no fault.
  - Timeout: the counter increments each GNTi cycle with axi_busy=1 and clears on any state exit. When counter == TIMEOUT_CYCLES-1 and axi_busy=1:
    - drive mi_busy=0 and mi_access_fault=1;
    - axi enables 0 that cycle;
    - last_grant <= i;
    - next state IDLE.
- The non-granted requester never sees access_fault; its rd_data is 0.
- Outputs when not in a completion cycle: rd_data 0, fault 0.
- grant = one-hot of GNT0/GNT1; 0 in IDLE.

Reset:
- Asynchronous assertion of rst_n mid-transfer forces IDLE immediately. All axi enables, busy outputs and faults go to 0, then follow the IDLE rules once rst_n deasserts.
- All outputs are 0 during reset.

Boundary conditions:
- Back-to-back requests from the same requester with no contention: each transfer pays the 1-cycle IDLE arbitration. Sustained single-requester throughput is 1 transfer / 2 cycles.
- Continuous contention strictly alternates 0,1,0,1.
- A new request arriving in the completion cycle of the other requester is arbitrated in the following IDLE cycle.

Test Plan:
- Reset, then m0_rd_en=1 addr=0x100, axi_busy=0, axi_rd_data=0xDEADBEEF -> cycle 0: m0_busy=1, axi_rd_en=0; cycle 1: axi_rd_en=1, axi_addr=0x100, m0_busy=0, m0_rd_data=0xDEADBEEF, grant=01.
- m0 and m1 write simultaneously and hold, axi_busy=0 -> grant sequence GNT0 (m0 completes), IDLE, GNT1 (m1 completes); axi_wr_data/strobe match each requester; neither request is lost.
- m1 read with axi_busy=1 for 3 cycles, then 0 with axi_access_fault=1 -> m1_busy=1 for 4 cycles (arbitration + 3 busy); completion cycle m1_busy=0, m1_access_fault=1.
- TIMEOUT_CYCLES=4, m0 read, axi_busy stuck at 1 -> 4th granted cycle: m0_busy=0, m0_access_fault=1, axi_rd_en=0; next cycle state IDLE.
- m0 requests, is granted, then drops rd_en while axi_busy=1 -> next cycle IDLE, no fault, last_grant unchanged, so m0 wins the next contention.
- rst_n pulsed low mid-GNT1 with axi_busy=1 -> axi_wr_en=0 immediately (asynchronous); after release, m1 is re-arbitrated from IDLE.
